// File: rtl/uart_tx_arb.sv
// Four-requester byte arbiter in front of a UART transmitter: latches the winning byte, launches a frame, waits for it to finish, then idles for a gap.
// Optional macro UART_TX_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority with req[0] highest.
module uart_tx_arb #(
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic        err
);

  // state     | meaning
  // IDLE      | transmitter free, arbitrating
  // LAUNCH    | winner latched and acked, tx_wr goes high next
  // WAIT_BUSY | tx_wr high, waiting for tx_busy or timeout
  // WAIT_DONE | frame in progress
  // GAP       | GAP_CYC idle clocks before grant is released
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] grant_nxt, ack_nxt;
  logic [7:0] tx_data_nxt;
  logic       tx_wr_nxt, err_nxt;
  logic [1:0] win_idx;
  logic       win_vld;

`ifdef UART_TX_ARB_RR_EN
  logic [1:0] ptr, ptr_nxt;

  // Descending scan so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr + 2'(k);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        win_vld = 1'b1;
        win_idx = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    tx_data_nxt = tx_data;
    tx_wr_nxt   = tx_wr;
    ack_nxt     = 4'b0000;
    err_nxt     = 1'b0;
`ifdef UART_TX_ARB_RR_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE: begin
        if (win_vld && !tx_busy) begin
          tx_data_nxt = req_data[{win_idx, 3'b000} +: 8];
          grant_nxt   = 4'b0001 << win_idx;
          ack_nxt     = 4'b0001 << win_idx;
`ifdef UART_TX_ARB_RR_EN
          ptr_nxt     = win_idx + 2'd1;
`endif
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_wr_nxt = 1'b1;
        cnt_nxt   = 8'd0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          tx_wr_nxt = 1'b0;
          state_nxt = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          // Transmitter never started: abandon the byte and still honour the gap.
          tx_wr_nxt = 1'b0;
          err_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_nxt   = 8'd0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          grant_nxt = 4'b0000;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      grant   <= 4'b0000;
      ack     <= 4'b0000;
      tx_data <= 8'h00;
      tx_wr   <= 1'b0;
      err     <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
      ptr     <= 2'd0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      grant   <= grant_nxt;
      ack     <= ack_nxt;
      tx_data <= tx_data_nxt;
      tx_wr   <= tx_wr_nxt;
      err     <= err_nxt;
`ifdef UART_TX_ARB_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: UART line model plus a request-level arbitration reference model.
module tb_uart_tx_arb;
  localparam int GAP_CYC = 16;
  localparam int TMO_CYC = 15;
`ifdef UART_TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  ack, grant;
  logic [7:0]  tx_data;
  logic        tx_wr, err;
  logic        tx_busy;

  logic force_busy = 1'b0;
  logic no_busy = 1'b0;
  logic line_busy = 1'b0;
  logic wr_prev = 1'b0;
  int   busy_dly = 2;
  int   busy_len = 169;
  int   start_cnt = 0;
  int   hold_cnt = 0;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  uart_tx_arb #(.GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .err(err)
  );

  always #5 clk = ~clk;
  assign tx_busy = force_busy | line_busy;

  // UART line: busy rises busy_dly clocks after a tx_wr rise and stays up busy_len clocks.
  always @(negedge clk) begin
    if (rst) begin
      line_busy = 1'b0; start_cnt = 0; hold_cnt = 0; wr_prev = 1'b0;
    end else begin
      if (tx_wr && !wr_prev && !no_busy) start_cnt = busy_dly;
      else if (start_cnt > 0) begin
        start_cnt--;
        if (start_cnt == 0) begin line_busy = 1'b1; hold_cnt = busy_len; end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) line_busy = 1'b0;
      end
      wr_prev = tx_wr;
    end
  end

  function automatic int pick_idx(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic note_ack(input int idx);
    if (RR) model_ptr = (idx + 1) % 4;
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_ack(output logic [3:0] a, output bit ok);
    a = 4'b0000; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ack != 4'b0000) begin a = ack; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_free(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (grant == 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0; model_ptr = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %h want 0", grant); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr got %b want 0", tx_wr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0; model_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] a; bit ok;
    int wr_cyc, fall_at, free_at; bit busy_seen, unstable;
    busy_dly = 2; busy_len = 169;
    req_data = $urandom; req_data[23:16] = 8'hA5; req = 4'b0100;
    wait_ack(a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_ack_wait got none want ack"); end
    checks++; if (a !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", a); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant); end
    note_ack(2);
    req = 4'b0000; req_data = $urandom;
    tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse got %b want 0000", ack); end
    wr_cyc = (tx_wr === 1'b1) ? 1 : 0; fall_at = -1; free_at = -1; busy_seen = 0; unstable = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tx_wr) wr_cyc++;
      if (busy_seen && !tx_busy && fall_at < 0) fall_at = i;
      if (tx_busy) busy_seen = 1;
      if (grant == 4'b0000) begin free_at = i; break; end
      if (tx_data !== 8'hA5 || grant !== 4'b0100) unstable = 1;
    end
    checks++; if (wr_cyc < 1 || wr_cyc > 3) begin errors++; $display("FAIL single_tx_wr_len got %0d want 1..3", wr_cyc); end
    checks++; if (unstable) begin errors++; $display("FAIL single_stable got changed want held"); end
    checks++; if (fall_at < 0 || free_at != fall_at + GAP_CYC + 1) begin
      errors++; $display("FAIL single_gap got %0d want %0d", free_at - fall_at, GAP_CYC + 1);
    end
  endtask

  task automatic test_contention();
    logic [3:0] a; bit ok;
    busy_dly = 2; busy_len = 8;
`ifdef UART_TX_ARB_RR_EN
    do_reset();
    req_data = 32'h13121110; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(a, ok);
      checks++; if (a !== 4'(1 << (n % 4))) begin errors++; $display("FAIL rr_ack%0d got %b want %b", n, a, 4'(1 << (n % 4))); end
      checks++; if (tx_data !== 8'(8'h10 + n % 4)) begin errors++; $display("FAIL rr_data%0d got %h want %h", n, tx_data, 8'(8'h10 + n % 4)); end
      note_ack(n % 4);
    end
`else
    req_data = $urandom; req = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      wait_ack(a, ok);
      checks++; if (a !== 4'b0010) begin errors++; $display("FAIL fix_ack%0d got %b want 0010", n, a); end
      checks++; if (tx_data !== req_data[15:8]) begin errors++; $display("FAIL fix_data%0d got %h want %h", n, tx_data, req_data[15:8]); end
    end
    req = 4'b1000;
    wait_ack(a, ok);
    checks++; if (a !== 4'b1000) begin errors++; $display("FAIL fix_ack_low got %b want 1000", a); end
    checks++; if (tx_data !== req_data[31:24]) begin errors++; $display("FAIL fix_data_low got %h want %h", tx_data, req_data[31:24]); end
`endif
    req = 4'b0000;
    wait_free(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_free got busy want grant 0"); end
  endtask

  task automatic test_random();
    logic [3:0] a, r; logic [31:0] d; bit ok; int e;
    for (int n = 0; n < 10; n++) begin
      r = 4'($urandom_range(1, 15)); d = $urandom;
      busy_dly = $urandom_range(1, 3); busy_len = $urandom_range(3, 20);
      e = pick_idx(r, RR ? model_ptr : 0);
      req = r; req_data = d;
      wait_ack(a, ok);
      checks++; if (a !== 4'(1 << e)) begin errors++; $display("FAIL rand_ack%0d req %b got %b want %b", n, r, a, 4'(1 << e)); end
      checks++; if (tx_data !== d[e*8 +: 8]) begin errors++; $display("FAIL rand_data%0d got %h want %h", n, tx_data, d[e*8 +: 8]); end
      note_ack(e);
      req = 4'b0000; req_data = $urandom;
      wait_free(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_free%0d got busy want grant 0", n); end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] a; logic [7:0] d; bit ok; int t_wr, t_err, err_n; bit clash;
    no_busy = 1'b1;
    d = 8'($urandom); req_data = {24'h0, d}; req = 4'b0001;
    wait_ack(a, ok);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL tmo_ack got %b want 0001", a); end
    note_ack(0);
    req = 4'b0000;
    t_wr = -1; t_err = -1; err_n = 0; clash = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_wr && t_wr < 0) t_wr = i;
      if (err) begin
        t_err = i; err_n++;
        if (tx_wr !== 1'b0 || ack !== 4'b0000) clash = 1;
      end
      if (grant == 4'b0000) break;
    end
    checks++; if (t_wr < 0 || t_err - t_wr != TMO_CYC) begin errors++; $display("FAIL tmo_delay got %0d want %0d", t_err - t_wr, TMO_CYC); end
    checks++; if (err_n != 1) begin errors++; $display("FAIL tmo_err_pulse got %0d want 1", err_n); end
    checks++; if (clash) begin errors++; $display("FAIL tmo_err_with_wr_or_ack got overlap want none"); end
    no_busy = 1'b0; busy_dly = 2; busy_len = 10;
    req_data = $urandom; req = 4'b0100;
    wait_ack(a, ok);
    checks++; if (a !== 4'b0100) begin errors++; $display("FAIL tmo_next_ack got %b want 0100", a); end
    checks++; if (tx_data !== req_data[23:16]) begin errors++; $display("FAIL tmo_next_data got %h want %h", tx_data, req_data[23:16]); end
    note_ack(2);
    req = 4'b0000;
    wait_free(ok);
  endtask

  task automatic test_reset_mid();
    logic [3:0] a; bit ok, seen;
    busy_dly = 2; busy_len = 50;
    req_data = $urandom; req = 4'b0001;
    wait_ack(a, ok);
    note_ack(0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (tx_busy) begin seen = 1; break; end end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_busy got 0 want 1"); end
    repeat (5) tick();
    rst = 1'b1; #1;
    checks++; if (grant !== 4'b0000 || ack !== 4'b0000 || tx_wr !== 1'b0 || tx_data !== 8'h00 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs got g=%b a=%b w=%b d=%h e=%b want all 0", grant, ack, tx_wr, tx_data, err);
    end
    repeat (3) tick();
    rst = 1'b0; model_ptr = 0;
    wait_ack(a, ok);
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL rmid_reack got %b want 0001", a); end
    note_ack(0);
    req = 4'b0000;
    wait_free(ok);
  endtask

  task automatic test_busy_idle();
    bit ok; int bad;
    force_busy = 1'b1; busy_len = 5;
    req_data = $urandom; req = 4'b0001; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack !== 4'b0000 || grant !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_idle_grant got %0d grants want 0", bad); end
    force_busy = 1'b0;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL busy_idle_ack got %b want 0001", ack); end
    note_ack(0);
    req = 4'b0000;
    wait_free(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_idle_free got busy want grant 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_random();
    test_timeout();
    test_reset_mid();
    test_busy_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
